// File: rtl/core_pkg.sv
// Shared core types and constants for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN/INST_W/PC_STEP constants, the prefetch bus FSM state
// enum and the {pc, inst} entry struct queued by the prefetch buffer.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } prefetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } prefetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO with flush; holds prefetched {pc, inst} entries.
// Latency: a push is visible at pop_dat the cycle after the write edge.
// Backpressure: push is dropped when full; pop is ignored when empty.
// Ports: clk, rst_n (async active-low); flush clears occupancy and wins
// over push/pop; push/push_dat write; pop/pop_dat read the head (zero when
// empty); full, empty and count report occupancy (0..DEPTH).
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Head is forced to zero when empty so the fetch outputs read as zero
  // after reset and after a flush.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: sequential word reads queued for the fetch stage.
// Latency: ack to fetch_valid is 1 cycle (0 with INST_PREFETCH_BYPASS_EN).
// Backpressure: stops issuing reads when the queue is full; redirect flushes.
// Ports: clk, rst_n (async active-low); redirect/redirect_pc restart fetch;
// fetch_valid/fetch_pc/fetch_inst/fetch_ready hand entries to fetch;
// mem_req/mem_addr/mem_ack/mem_rdata form the one-outstanding read bus.
// Optional macro INST_PREFETCH_BYPASS_EN: present the acked word to fetch
// combinationally when the queue is empty.
module inst_prefetch
  import core_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   fetch_pc,
  output logic [INST_W-1:0] fetch_inst,
  input  logic              fetch_ready,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  prefetch_state_t state_q, state_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] addr_inc;
  logic [XLEN-1:0] redirect_aligned;

  logic            ack_take;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   cnt_post;
  prefetch_entry_t push_entry;
  prefetch_entry_t head;

  assign addr_inc         = addr_q + XLEN'(PC_STEP);
  assign redirect_aligned = redirect_pc & ~XLEN'(PC_STEP - 1);

  // A word is accepted only from REQ and only when no redirect voids it;
  // acks seen in DRAIN or alongside a redirect are thrown away.
  assign ack_take   = (state_q == REQ) && mem_ack && !redirect;
  assign push_entry = '{pc: addr_q, inst: mem_rdata};
  assign pop        = !fifo_empty && fetch_ready && !redirect;

`ifdef INST_PREFETCH_BYPASS_EN
  logic byp_hit;

  assign byp_hit     = fifo_empty && ack_take;
  assign fetch_valid = !fifo_empty || byp_hit;
  assign fetch_pc    = byp_hit ? addr_q    : head.pc;
  assign fetch_inst  = byp_hit ? mem_rdata : head.inst;
  // A bypassed word taken by fetch in the ack cycle never enters the queue.
  assign push        = ack_take && !(byp_hit && fetch_ready);
`else
  assign fetch_valid = !fifo_empty;
  assign fetch_pc    = head.pc;
  assign fetch_inst  = head.inst;
  assign push        = ack_take;
`endif

  // Occupancy after this edge; decides whether the next read can start
  // back to back without risking an ack with no free slot.
  assign cnt_post = fifo_count + CW'(push) - CW'(pop);

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(prefetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    next_pc_d = next_pc_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (!fifo_full && !redirect) begin
          addr_d  = next_pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          // Without an ack the read is still in flight and must be waited out.
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          next_pc_d = addr_inc;
          if (cnt_post < CW'(DEPTH)) begin
            addr_d  = addr_inc;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) next_pc_d = redirect_aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      next_pc_q <= RESET_PC;
      addr_q    <= RESET_PC;
    end else begin
      state_q   <= state_d;
      next_pc_q <= next_pc_d;
      addr_q    <= addr_d;
    end
  end

  assign mem_req  = (state_q != IDLE);
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomised bench for inst_prefetch against a stream/occupancy reference.
// The model tracks the expected fetch stream, request addresses and queue
// occupancy from the bus and fetch handshakes, sampled on the falling edge.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INST_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  inst_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_ready (fetch_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Program memory contents: an address-dependent pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return r;
  endfunction

  // ---------------- reference model ----------------
  int          occ;
  logic        exp_req;
  logic [31:0] exp_addr;
  logic [31:0] exp_fetch_pc;
  logic        draining;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          acc_total = 0;
  int          fire_total = 0;

  always @(negedge clk) begin : monitor
    logic acc;
    logic fire;
    logic ev;
    int   occ_old;
    if (!rst_n) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, RESET_PC);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_fetch_pc", fetch_pc, 32'd0);
      chk("rst_fetch_inst", fetch_inst, 32'd0);
      occ          = 0;
      exp_req      = 1'b0;
      exp_addr     = RESET_PC;
      exp_fetch_pc = RESET_PC;
      draining     = 1'b0;
      prev_req     = 1'b0;
      prev_ack     = 1'b0;
      prev_addr    = '0;
    end else begin
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (mem_req) begin
        if (prev_req && !prev_ack) chk("addr_hold", mem_addr, prev_addr);
        else                       chk("req_addr", mem_addr, exp_addr);
      end
      acc = mem_req && mem_ack && !redirect && !draining;
      ev  = (occ != 0) || (BYP && acc);
      chk("fetch_valid", 32'(fetch_valid), 32'(ev));
      if (ev && fetch_valid) begin
        chk("fetch_pc", fetch_pc, exp_fetch_pc);
        chk("fetch_inst", fetch_inst, mem_word(exp_fetch_pc));
      end
      fire    = ev && fetch_ready && !redirect;
      occ_old = occ;
      if (redirect) begin
        occ          = 0;
        exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        exp_addr     = redirect_pc & 32'hFFFF_FFFC;
        exp_req      = mem_req && !mem_ack;
      end else begin
        occ = occ + int'(acc) - int'(fire);
        if (fire) exp_fetch_pc = exp_fetch_pc + 32'd4;
        if (acc)  exp_addr = exp_addr + 32'd4;
        if (mem_req) exp_req = mem_ack ? (acc && occ < DEPTH) : 1'b1;
        else         exp_req = (occ_old < DEPTH);
      end
      if (mem_ack)               draining = 1'b0;
      else if (mem_req && redirect) draining = 1'b1;
      acc_total  += int'(acc);
      fire_total += int'(fire);
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  // ---------------- stimulus ----------------
  int wcnt = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bus(input int p_ack, input int wait_n);
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wait_n > 0) begin
      if (wcnt >= wait_n) begin
        mem_ack = 1'b1;
        wcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = ($urandom_range(99) < p_ack);
    end
    mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom;
  endtask

  task automatic run(input int n, input int p_ack, input int wait_n,
                     input int p_rdy, input int p_redir);
    for (int i = 0; i < n; i++) begin
      cycle();
      redirect    = ($urandom_range(99) < p_redir);
      redirect_pc = rand_pc();
      fetch_ready = ($urandom_range(99) < p_rdy);
      drive_bus(p_ack, wait_n);
    end
  endtask

  // Advance with ack following mem_req until fetch_valid is seen.
  task automatic wait_fetch(input logic rdy, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      redirect    = 1'b0;
      fetch_ready = rdy;
      mem_ack     = mem_req;
      mem_rdata   = mem_word(mem_addr);
      @(negedge clk);
      found = fetch_valid;
    end
  endtask

  // Advance with acks held off until a request is pending.
  task automatic wait_req(output logic found);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      redirect    = 1'b0;
      fetch_ready = 1'b1;
      mem_ack     = 1'b0;
      found       = mem_req;
    end
  endtask

  initial begin
    int   a0;
    int   f0;
    logic ok;

    // Reset, then zero-wait streaming with fetch always ready.
    repeat (3) cycle();
    cycle();
    rst_n = 1'b1; fetch_ready = 1'b1; mem_ack = 1'b0;
    f0 = fire_total;
    run(40, 100, 0, 100, 0);
    settle();
    chk("stream_fires", 32'(fire_total - f0), BYP ? 32'd40 : 32'd39);

    // Backpressure from an empty queue with a request pending.
    run(6, 0, 0, 100, 0);
    a0 = acc_total;
    run(12, 100, 0, 0, 0);
    settle();
    chk("bp_acks", 32'(acc_total - a0), 32'(DEPTH));
    chk("bp_req_low", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(fetch_valid), 32'd1);
    run(10, 100, 0, 100, 0);

    // Three wait states per read.
    run(40, 0, 3, 70, 0);

    // Redirect during a pending read: the drained word must never surface.
    wait_req(ok);
    chk("drain_req_found", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_1003; mem_ack = 1'b0;
    cycle(); redirect = 1'b0; mem_ack = 1'b0;
    cycle(); mem_ack = 1'b0;
    cycle(); mem_ack = mem_req; mem_rdata = mem_word(mem_addr);
    wait_fetch(1'b0, ok);
    chk("drain_fetch_found", 32'(ok), 32'd1);
    chk("drain_first_pc", fetch_pc, 32'h0000_1000);
    run(10, 100, 0, 100, 0);

    // Redirect with same-cycle ack and pop, queue one short of full.
    run(6, 0, 0, 100, 0);
    a0 = acc_total;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cycle();
      redirect    = 1'b0;
      fetch_ready = 1'b0;
      if (mem_req && (acc_total - a0) == DEPTH - 1) begin
        ok      = 1'b1;
        mem_ack = 1'b0;
      end else begin
        mem_ack = mem_req;
      end
      mem_rdata = mem_word(mem_addr);
    end
    chk("nearfull_reached", 32'(ok), 32'd1);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_2468; fetch_ready = 1'b1;
    mem_ack = mem_req; mem_rdata = mem_word(mem_addr);
    cycle();
    redirect = 1'b0; mem_ack = 1'b0;
    settle();
    chk("nearfull_redir_valid", 32'(fetch_valid), 32'd0);
    run(10, 100, 0, 100, 0);

    // Redirect with pop on a full queue.
    run(12, 100, 0, 0, 0);
    cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_3000; fetch_ready = 1'b1; mem_ack = 1'b0;
    cycle();
    redirect = 1'b0;
    settle();
    chk("full_redir_valid", 32'(fetch_valid), 32'd0);
    chk("full_redir_req", 32'(mem_req), 32'd0);
    run(10, 100, 0, 100, 0);

    // Address wrap.
    cycle();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; fetch_ready = 1'b1; mem_ack = 1'b0;
    wait_fetch(1'b1, ok);
    chk("wrap_found", 32'(ok), 32'd1);
    chk("wrap_pc0", fetch_pc, 32'hFFFF_FFFC);
    cycle();
    mem_ack = mem_req; mem_rdata = mem_word(mem_addr);
    @(negedge clk);
    chk("wrap_valid1", 32'(fetch_valid), 32'd1);
    chk("wrap_pc1", fetch_pc, 32'h0000_0000);

    // Random mixes.
    run(3000, 60, 0, 60, 3);
    run(1000, 30, 0, 90, 1);

    // Reset asserted mid-request.
    wait_req(ok);
    chk("rst_req_found", 32'(ok), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, RESET_PC);
    chk("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1; mem_ack = 1'b0; fetch_ready = 1'b1; redirect = 1'b0;
    run(20, 100, 0, 100, 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
